// File: rtl/frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : frame_bank_scheduler
//  Description : Ping-pong write steering for a two-bank frame buffer. Pixels
//                go to the back bank; the banks swap only when a frame has
//                delivered its last pixel and the closing packet passed CRC.
//                Killed, short or stalled frames are dropped and counted.
//  Option      : FRAME_BANK_FULL_CHECK_EN - commit also requires the pixel
//                counter to have reached FRAME_PIXELS.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_bank_scheduler #(
  parameter int FRAME_PIXELS   = 76800,
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_axiiv,
  input  logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [7:0]            pix_data,
  input  logic                  pkt_done,
  input  logic                  pkt_kill,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_bank,
  output logic                  frame_swap,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int                  PCW       = $clog2(FRAME_PIXELS + 1);
  localparam logic [ADDR_WIDTH:0]   FP_EXT    = (ADDR_WIDTH + 1)'(FRAME_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [PCW-1:0]        PIX_FULL  = PCW'(FRAME_PIXELS);
  localparam logic [PCW-1:0]        PIX_ONE   = PCW'(1);
  localparam logic [19:0]           TO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_COMMIT    = 3'd3,
    S_DROP      = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] pix_cnt, pix_cnt_nxt, pix_inc, cnt_after;
  logic [19:0]    to_cnt, to_cnt_nxt;
  logic           in_range, last_beat, rd_bank_nxt, commit_ok;

  // Out-of-range beats are invisible: no write, no count, no state change.
  assign in_range  = pix_axiiv && ({1'b0, pix_addr} < FP_EXT);
  assign last_beat = in_range && (pix_addr == LAST_ADDR);
  assign busy      = (state == S_FILL) || (state == S_WAIT_DONE);

  // Next-state, counter and front-bank decisions; the current beat is
  // folded in before any end-of-packet decision.
  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    to_cnt_nxt  = to_cnt;
    rd_bank_nxt = rd_bank;
    pix_inc     = (pix_cnt == PIX_FULL) ? pix_cnt : pix_cnt + PIX_ONE;
    cnt_after   = in_range ? pix_inc : pix_cnt;
`ifdef FRAME_BANK_FULL_CHECK_EN
    commit_ok   = (cnt_after == PIX_FULL);
`else
    commit_ok   = 1'b1;
`endif
    case (state)
      S_IDLE: begin
        if (in_range) begin
          state_nxt   = S_FILL;
          pix_cnt_nxt = PIX_ONE;
          to_cnt_nxt  = 20'd0;
        end
      end
      S_FILL, S_WAIT_DONE: begin
        pix_cnt_nxt = cnt_after;
        to_cnt_nxt  = in_range ? 20'd0 : to_cnt + 20'd1;
        if (pkt_done && pkt_kill) begin
          state_nxt = S_DROP;
        end else if (pkt_done && ((state == S_WAIT_DONE) || last_beat)) begin
          state_nxt = commit_ok ? S_COMMIT : S_DROP;
        end else if (!in_range && (to_cnt == TO_LAST)) begin
          state_nxt = S_DROP;
        end else if (last_beat) begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_COMMIT, S_DROP: begin
        // A beat landing here opens the next frame immediately.
        if (state == S_COMMIT) begin
          rd_bank_nxt = ~rd_bank;
        end
        state_nxt   = in_range ? S_FILL : S_IDLE;
        pix_cnt_nxt = in_range ? PIX_ONE : '0;
        to_cnt_nxt  = 20'd0;
      end
      default: begin
        state_nxt   = S_IDLE;
        pix_cnt_nxt = '0;
        to_cnt_nxt  = 20'd0;
      end
    endcase
  end

  // State, counters and registered write port; the write bank is always the
  // complement of the front bank that will be in force next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      to_cnt     <= 20'd0;
      rd_bank    <= 1'b0;
      frame_swap <= 1'b0;
      drop_count <= 16'd0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= pix_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      rd_bank    <= rd_bank_nxt;
      frame_swap <= (state == S_COMMIT);
      if ((state == S_DROP) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      wr_en      <= in_range;
      wr_addr    <= {~rd_bank_nxt, pix_addr};
      wr_data    <= pix_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_bank_scheduler
//  Description : Directed self-checking bench for frame_bank_scheduler with a
//                16-pixel frame and a 100-cycle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_bank_scheduler;

  localparam int FP = 16;
  localparam int AW = 5;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_axiiv = 1'b0;
  logic [AW-1:0] pix_addr = '0;
  logic [7:0]    pix_data = 8'd0;
  logic          pkt_done = 1'b0;
  logic          pkt_kill = 1'b0;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [7:0]    wr_data;
  logic          rd_bank;
  logic          frame_swap;
  logic [15:0]   drop_count;
  logic          busy;

  int tests = 0;
  int fails = 0;
  logic        exp_rd = 1'b0;
  logic [15:0] exp_drop = 16'd0;

  frame_bank_scheduler #(.FRAME_PIXELS(FP), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pix_axiiv(pix_axiiv), .pix_addr(pix_addr), .pix_data(pix_data),
    .pkt_done(pkt_done), .pkt_kill(pkt_kill), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .frame_swap(frame_swap),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [7:0] d, input logic done, input logic kill);
    pix_axiiv = 1'b1; pix_addr = a; pix_data = d; pkt_done = done; pkt_kill = kill;
    step();
    pix_axiiv = 1'b0; pkt_done = 1'b0; pkt_kill = 1'b0;
  endtask

  task automatic done_pulse(input logic kill);
    pkt_done = 1'b1; pkt_kill = kill;
    step();
    pkt_done = 1'b0; pkt_kill = 1'b0;
  endtask

  // Sends addresses lo..hi with data = addr ^ salt and checks every write.
  task automatic write_run(input int lo, input int hi, input logic [7:0] salt);
    for (int a = lo; a <= hi; a++) begin
      beat(AW'(a), 8'(a) ^ salt, 1'b0, 1'b0);
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== {~exp_rd, AW'(a)} || wr_data !== (8'(a) ^ salt)) begin
        fails++;
        $display("FAIL write a=%0d: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
                 a, wr_en, wr_addr, wr_data, {~exp_rd, AW'(a)}, 8'(a) ^ salt);
      end
    end
  endtask

  // Checks the two cycles after pkt_done for a swap (or its absence).
  task automatic expect_end(input string name, input logic swap);
    tests++;
    if (frame_swap !== 1'b0 || rd_bank !== exp_rd) begin
      fails++;
      $display("FAIL %s early: got swap=%b rd=%b expected swap=0 rd=%b", name, frame_swap, rd_bank, exp_rd);
    end
    step();
    if (swap) exp_rd = ~exp_rd;
    else exp_drop = exp_drop + 16'd1;
    tests++;
    if (frame_swap !== swap || rd_bank !== exp_rd || drop_count !== exp_drop || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: got swap=%b rd=%b drop=%0d busy=%b expected swap=%b rd=%b drop=%0d busy=0",
               name, frame_swap, rd_bank, drop_count, busy, swap, exp_rd, exp_drop);
    end
    step();
    tests++;
    if (frame_swap !== 1'b0) begin
      fails++;
      $display("FAIL %s swap_len: got swap=%b expected 0", name, frame_swap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    tests++;
    if (rd_bank !== 1'b0 || wr_en !== 1'b0 || drop_count !== 16'd0 || busy !== 1'b0 || frame_swap !== 1'b0) begin
      fails++;
      $display("FAIL reset: got rd=%b en=%b drop=%0d busy=%b swap=%b expected all 0",
               rd_bank, wr_en, drop_count, busy, frame_swap);
    end
  endtask

  task automatic test_commit();
    write_run(0, FP - 1, 8'h00);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL commit_busy: got %b expected 1", busy);
    end
    done_pulse(1'b0);
    expect_end("commit", 1'b1);
  endtask

  task automatic test_back_to_back();
    write_run(0, FP - 1, 8'h5A);
    done_pulse(1'b0);
    expect_end("back_to_back", 1'b1);
  endtask

  task automatic test_kill();
    write_run(0, FP - 1, 8'hC3);
    done_pulse(1'b1);
    expect_end("kill", 1'b0);
  endtask

  task automatic test_timeout();
    int kb = -1;
    int kd = -1;
    write_run(0, 7, 8'h11);
    for (int k = 1; k <= 200; k++) begin
      step();
      if (kb < 0 && busy === 1'b0) kb = k;
      if (kd < 0 && drop_count === exp_drop + 16'd1) kd = k;
      if (kb >= 0 && kd >= 0) break;
    end
    exp_drop = exp_drop + 16'd1;
    tests++;
    if (kb != TO) begin
      fails++;
      $display("FAIL timeout_busy: got busy fall at %0d expected %0d", kb, TO);
    end
    tests++;
    if (kd != TO + 1 || rd_bank !== exp_rd) begin
      fails++;
      $display("FAIL timeout_drop: got count at %0d rd=%b expected %0d rd=%b", kd, rd_bank, TO + 1, exp_rd);
    end
  endtask

  task automatic test_out_of_range();
    beat(AW'(FP), 8'h77, 1'b0, 1'b0);
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL oor_16: got en=%b busy=%b expected en=0 busy=0", wr_en, busy);
    end
    beat(AW'(31), 8'h78, 1'b0, 1'b0);
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL oor_31: got en=%b busy=%b expected en=0 busy=0", wr_en, busy);
    end
  endtask

  task automatic test_full_check();
    write_run(0, 3, 8'h22);
    write_run(FP - 1, FP - 1, 8'h22);
    done_pulse(1'b0);
`ifdef FRAME_BANK_FULL_CHECK_EN
    expect_end("full_check", 1'b0);
`else
    expect_end("full_check", 1'b1);
`endif
  endtask

  task automatic test_last_with_done();
    write_run(0, FP - 2, 8'h33);
    beat(AW'(FP - 1), 8'h99, 1'b1, 1'b0);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== {~exp_rd, AW'(FP - 1)} || busy !== 1'b0) begin
      fails++;
      $display("FAIL last_done: got en=%b addr=%h busy=%b expected en=1 addr=%h busy=0",
               wr_en, wr_addr, busy, {~exp_rd, AW'(FP - 1)});
    end
    expect_end("last_done", 1'b1);
  endtask

  task automatic test_poison();
    write_run(0, 5, 8'h44);
    done_pulse(1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL poison_busy: got %b expected 0", busy);
    end
    beat(AW'(6), 8'h66, 1'b0, 1'b0);
    exp_drop = exp_drop + 16'd1;
    tests++;
    if (drop_count !== exp_drop || busy !== 1'b1 || wr_en !== 1'b1 || wr_addr !== {~exp_rd, AW'(6)}) begin
      fails++;
      $display("FAIL poison_restart: got drop=%0d busy=%b en=%b addr=%h expected drop=%0d busy=1 en=1 addr=%h",
               drop_count, busy, wr_en, wr_addr, exp_drop, {~exp_rd, AW'(6)});
    end
  endtask

  task automatic test_beat_in_commit();
    write_run(0, FP - 2, 8'h55);
    beat(AW'(FP - 1), 8'h01, 1'b1, 1'b0);
    beat(AW'(2), 8'hAB, 1'b0, 1'b0);
    exp_rd = ~exp_rd;
    tests++;
    if (rd_bank !== exp_rd || frame_swap !== 1'b1 || wr_en !== 1'b1 ||
        wr_addr !== {~exp_rd, AW'(2)} || wr_data !== 8'hAB || busy !== 1'b1) begin
      fails++;
      $display("FAIL beat_in_commit: got rd=%b swap=%b en=%b addr=%h data=%h busy=%b expected rd=%b swap=1 en=1 addr=%h data=ab busy=1",
               rd_bank, frame_swap, wr_en, wr_addr, wr_data, busy, exp_rd, {~exp_rd, AW'(2)});
    end
  endtask

  task automatic test_reset_midframe();
    write_run(3, 5, 8'h0F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    tests++;
    if (drop_count !== 16'd0 || rd_bank !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_midframe: got drop=%0d rd=%b busy=%b en=%b expected all 0",
               drop_count, rd_bank, busy, wr_en);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_back_to_back();
    test_kill();
    test_timeout();
    test_out_of_range();
    test_full_check();
    test_last_with_done();
    test_poison();
    test_beat_in_commit();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
